sample_enable_gen: RTL and testbench
====================================

# sample_enable_gen

Parametrised, multi-channel successor to the transmitter's sample-enable control unit. Divides the 12.5 MHz system clock to a programmable sampling clock and produces per-channel enables that are gated off by each channel's `tx_complete` and re-armed every sampling period. It adds start/stop control, an optional sample-count auto-stop and status outputs. It sits between the transmitter sequencer and the per-channel modulators.

## Interface
- `CNT_W`, 32: width of the divider counter and `div_val`.
- `N_CH`, 4: number of enable channels.
- `NS_W`, 16: width of the sample counter and `n_samples`.
- `clk` in 1: system clock (12.5 MHz).
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a run; sampled in IDLE only.
- `stop` in 1: end the run after the current sampling period; ignored in IDLE.
- `div_val` in CNT_W: half-period terminal count; 0 is treated as 1; latched on accepted `start`.
- `n_samples` in NS_W: sample periods per run; 0 means continuous; latched on accepted `start`.
- `ch_mask` in N_CH: channels participating; latched on accepted `start`.
- `tx_complete` in N_CH: per-channel completion, level-sensitive.
- `out_clk` out 1: divided sampling clock, registered.
- `enable` out N_CH: per-channel gated enable.
- `sample_tick` out 1: 1-cycle pulse on each `out_clk` rising edge.
- `busy` out 1: high in RUN or DRAIN.
- `done` out 1: 1-cycle pulse on return to IDLE.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `count`=0, `out_clk`=0. On `start`: latch `div_q`, `ns_q` and `mask_q`, clear the sample counter, set every `gate[i]` to 1, then go to RUN.
- RUN and DRAIN divider:
  - If `count==div_q`: `count` becomes 0 and `out_clk` toggles.
  - Otherwise `count` increments.
- Half-period is `div_q+1` cycles. Full period is `2*(div_q+1)` cycles.
- Gate, per channel:
  - If `count==0`: `gate[i]` becomes `mask_q[i]`. Re-arm has priority.
  - Else if `tx_complete[i]`: `gate[i]` becomes 0.
- `enable[i]` = `gate[i] & out_clk & busy`.
- `sample_tick` is registered and is high in the first cycle `out_clk` reads 1. Each tick increments the sample counter, saturating at its maximum.
- RUN to DRAIN happens on either:
  - `stop`, or
  - the tick that makes the counter equal `ns_q` when `ns_q`≠0.
- DRAIN to IDLE:
  - At the wrap that drives `out_clk` to 0.
  - If `out_clk` is already 0 on DRAIN entry, on the next cycle.
  - On this transition, `done` pulses, `count` is set to 0 and `out_clk` is 0.
- Simultaneous events:
  - `start`+`stop` in IDLE: start wins.
  - `stop` in DRAIN: no effect.
  - `start` while busy: ignored.
  - Changing inputs while busy has no effect until the next run.
- `rst` mid-run: immediate return to IDLE. No `done` pulse.

## Timing
- Reset values: state IDLE, `count` 0, `out_clk` 0, `gate` all 1, `enable` 0, `sample_tick` 0, `busy` 0, `done` 0, sample counter 0.
- All outputs are registered except `enable`, which is an AND of registers only and introduces no input-to-output path.
- Cycle 0 is the first RUN cycle, with `busy`=1 and `count`=0.
- First `out_clk` rise is at cycle `div_q+1`. Ticks then repeat every `2*(div_q+1)` cycles.
- `tx_complete[i]` asserted in cycle t (t not a wrap-to-0 cycle) drops `enable[i]` at t+1. It stays low until the next `count==0` re-arm.

## Configuration
- `SAMPLE_CNT_EN` defined: sample counter, `n_samples` latch and auto-stop are compiled in.
- Undefined: no sample counter. `n_samples` is ignored and runs stop only via `stop`. `sample_tick`, `busy` and `done` are unchanged.

## Test plan
- Reset then idle: `rst` pulse with `start`=0 -> all outputs 0 and `out_clk` static for 100 cycles.
- Divider: `div_val`=2, `n_samples`=0, `ch_mask`=4'b1111, `start` -> `out_clk` rises at cycles 3, 9, 15 with a 6-cycle period; `sample_tick` at those same cycles; `enable`=4'hF while `out_clk`=1.
- Auto-stop (`SAMPLE_CNT_EN`): `div_val`=2, `n_samples`=3 -> exactly 3 ticks (cycles 3, 9, 15); `out_clk` falls and `done` pulses at cycle 18; `busy`=0 from cycle 19.
- Gating: `div_val`=4, `tx_complete[1]` high at cycle 7 -> `enable[1]`=0 from cycle 8; `enable[1]` re-armed for the next high phase; other channels unaffected. `ch_mask`=4'b0101 -> `enable[1]` and `enable[3]` never assert.
- Stop and corners: `stop` at cycle 4 with `div_val`=2 -> high phase completes, `done` at cycle 6. `div_val`=0 behaves as 1 (period 4). `start` while busy is ignored. `rst` at cycle 5 -> IDLE next cycle with no `done`.

Source files
------------

// File: rtl/sample_enable_gen.sv
// sample_enable_gen
//   Divides the system clock down to a programmable sampling clock and
//   produces per-channel enables. Each channel's enable is dropped by its
//   tx_complete and re-armed once per half-period when the divider counter
//   is at zero. Runs are started and stopped by the transmitter sequencer.
//
//   Optional feature macro: SAMPLE_CNT_EN
//     defined   -> sample counter, n_samples latch and auto-stop compiled in
//     undefined -> runs end only via stop; n_samples is ignored
//
// Ports
//   clk, rst       system clock, asynchronous active-high reset
//   start          begin a run (accepted in IDLE only)
//   stop           finish the run after the current sampling period
//   div_val        half-period terminal count (0 behaves as 1), latched on start
//   n_samples      sample periods per run, 0 = continuous, latched on start
//   ch_mask        participating channels, latched on start
//   tx_complete    per-channel completion, level-sensitive
//   out_clk        divided sampling clock (registered)
//   enable         per-channel enable = gate & out_clk & busy
//   sample_tick    1-cycle pulse in the first cycle out_clk is high
//   busy           high in RUN or DRAIN
//   done           1-cycle pulse closing a run
module sample_enable_gen #(
   parameter int CNT_W = 32,
   parameter int N_CH  = 4,
   parameter int NS_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [CNT_W-1:0] div_val,
   input  logic [NS_W-1:0]  n_samples,
   input  logic [N_CH-1:0]  ch_mask,
   input  logic [N_CH-1:0]  tx_complete,
   output logic             out_clk,
   output logic [N_CH-1:0]  enable,
   output logic             sample_tick,
   output logic             busy,
   output logic             done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [CNT_W-1:0] DIV_ONE = CNT_W'(1);

   logic [1:0]       state;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] div_q;
   logic [N_CH-1:0]  gate;
   logic [N_CH-1:0]  mask_q;
   logic             wrap;
   logic             rise;
   logic             auto_stop;

   assign wrap = (count == div_q);
   assign rise = wrap & ~out_clk;   // this wrap drives out_clk high

`ifdef SAMPLE_CNT_EN
   logic [NS_W-1:0] ns_q;
   logic [NS_W-1:0] scnt;
   logic [NS_W-1:0] scnt_nxt;

   // saturating increment; the stop test uses the post-increment value so
   // the run ends on the very tick that reaches ns_q
   assign scnt_nxt  = (scnt == '1) ? scnt : scnt + 1'b1;
   assign auto_stop = rise && (ns_q != '0) && (scnt_nxt == ns_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ns_q <= '0;
         scnt <= '0;
      end else if (state == S_IDLE) begin
         if (start) begin
            ns_q <= n_samples;
            scnt <= '0;
         end
      end else if (state == S_RUN && rise) begin
         scnt <= scnt_nxt;
      end
   end
`else
   logic unused_ns;
   assign unused_ns = ^n_samples;
   assign auto_stop = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         count       <= '0;
         out_clk     <= 1'b0;
         gate        <= '1;
         sample_tick <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_q       <= DIV_ONE;
         mask_q      <= '0;
      end else begin
         sample_tick <= 1'b0;
         done        <= 1'b0;

         // re-arm at count==0 wins over a completion in the same cycle
         if (state != S_IDLE)
            gate <= (count == '0) ? mask_q : (gate & ~tx_complete);

         case (state)
            S_IDLE: begin
               count   <= '0;
               out_clk <= 1'b0;
               if (start) begin
                  div_q  <= (div_val == '0) ? DIV_ONE : div_val;
                  mask_q <= ch_mask;
                  gate   <= '1;
                  busy   <= 1'b1;
                  state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (wrap) begin
                  count   <= '0;
                  out_clk <= ~out_clk;
               end else begin
                  count <= count + 1'b1;
               end
               sample_tick <= rise;
               if (stop || auto_stop)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               // done cycle: divider parked at 0/low, leave on the next edge
               if (done) begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else if (!out_clk || wrap) begin
                  count   <= '0;
                  out_clk <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  count <= count + 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign enable = gate & {N_CH{out_clk & busy}};

endmodule

// File: tb/tb_sample_enable_gen.sv
// tb_sample_enable_gen
//   Directed bench for sample_enable_gen: reset/idle, divider timing,
//   auto-stop (or its absence), channel gating and masking, stop timing,
//   div_val=0, start-while-busy and mid-run reset.
module tb_sample_enable_gen;
   localparam int CNT_W = 32;
   localparam int N_CH  = 4;
   localparam int NS_W  = 16;

   logic             clk = 1'b0;
   logic             rst, start, stop;
   logic [CNT_W-1:0] div_val;
   logic [NS_W-1:0]  n_samples;
   logic [N_CH-1:0]  ch_mask, tx_complete;
   logic             out_clk, sample_tick, busy, done;
   logic [N_CH-1:0]  enable;

   int n_tests = 0;
   int n_fail  = 0;

   always #40 clk = ~clk;   // 12.5 MHz

   sample_enable_gen #(.CNT_W(CNT_W), .N_CH(N_CH), .NS_W(NS_W)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .div_val(div_val), .n_samples(n_samples), .ch_mask(ch_mask),
      .tx_complete(tx_complete), .out_clk(out_clk), .enable(enable),
      .sample_tick(sample_tick), .busy(busy), .done(done)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // after return the bench is in cycle 0 of the run
   task automatic launch(input logic [CNT_W-1:0] d, input logic [NS_W-1:0] ns,
                         input logic [N_CH-1:0] m);
      div_val = d; n_samples = ns; ch_mask = m; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic finish_run();
      stop = 1'b1;
      step();
      stop = 1'b0;
      for (int i = 0; i < 200 && busy; i++) step();
      check("drain_bound", busy, 0);
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, ticks, last_tick, done_c, idle_c, ndone;
      rst = 1'b1; start = 1'b0; stop = 1'b0; div_val = '0; n_samples = '0;
      ch_mask = '0; tx_complete = '0;
      step(); step();
      rst = 1'b0;
      step();

      // ---- reset state and idle quiet period (start + stop both low)
      check("rst_out_clk", out_clk, 0);
      check("rst_enable",  enable, 0);
      check("rst_tick",    sample_tick, 0);
      check("rst_busy",    busy, 0);
      check("rst_done",    done, 0);
      acc = 0;
      for (int c = 0; c < 100; c++) begin
         acc |= {out_clk, enable, sample_tick, busy, done};
         step();
      end
      check("idle_quiet", acc, 0);

      // ---- divider: div 2 -> rises at 3, 9, 15, period 6
      launch(2, 0, 4'b1111);
      for (int c = 0; c < 18; c++) begin
         check($sformatf("div_oc@%0d", c), out_clk, ((c / 3) % 2));
         check($sformatf("div_tick@%0d", c), sample_tick,
               ((c % 3 == 0) && ((c / 3) % 2 == 1)) ? 1 : 0);
         check($sformatf("div_en@%0d", c), enable, out_clk ? 4'hF : 4'h0);
         check($sformatf("div_busy@%0d", c), busy, 1);
         step();
      end
      finish_run();

      // ---- n_samples = 3
      launch(2, 3, 4'b1111);
      ticks = 0; last_tick = -1; done_c = -1; idle_c = -1; ndone = 0;
      for (int c = 0; c < 25; c++) begin
         if (sample_tick) begin ticks++; last_tick = c; end
         if (done) begin ndone++; if (done_c < 0) done_c = c; end
         if (!busy && idle_c < 0) idle_c = c;
`ifdef SAMPLE_CNT_EN
         if (c == 18) check("as_oc_fall@18", out_clk, 0);
`endif
         step();
      end
`ifdef SAMPLE_CNT_EN
      check("as_ticks", ticks, 3);
      check("as_last_tick", last_tick, 15);
      check("as_done_cycle", done_c, 18);
      check("as_done_count", ndone, 1);
      check("as_idle_cycle", idle_c, 19);
`else
      check("cont_ticks", ticks, 4);
      check("cont_busy", idle_c, -1);
      check("cont_no_done", ndone, 0);
`endif
      if (busy) finish_run();

      // ---- gating: div 4, high phases 5..9 and 15..19, tx_complete[1] at 7
      launch(4, 0, 4'b1111);
      for (int c = 0; c < 22; c++) begin
         if (c == 6)  check("gt_en@6",  enable, 4'hF);
         if (c == 7)  check("gt_en@7",  enable, 4'hF);
         if (c == 8)  check("gt_en@8",  enable, 4'b1101);
         if (c == 9)  check("gt_en@9",  enable, 4'b1101);
         if (c == 10) check("gt_en@10", enable, 4'h0);
         if (c == 15) check("gt_en@15", enable, 4'hF);
         if (c == 17) check("gt_en@17", enable, 4'hF);
         tx_complete = (c == 7) ? 4'b0010 : 4'b0000;
         step();
      end
      tx_complete = '0;
      finish_run();

      // ---- mask 0101: channels 1 and 3 never enable
      launch(2, 0, 4'b0101);
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         acc |= int'(enable & 4'b1010);
         if (c == 3) check("mask_en@3", enable, 4'b0101);
         step();
      end
      check("mask_off", acc, 0);
      finish_run();

      // ---- stop in cycle 4, div 2: high phase finishes, done at 6
      launch(2, 0, 4'b1111);
      for (int c = 0; c < 9; c++) begin
         if (c == 5) begin
            check("stop_oc@5", out_clk, 1);
            check("stop_done@5", done, 0);
         end
         if (c == 6) begin
            check("stop_oc@6", out_clk, 0);
            check("stop_done@6", done, 1);
            check("stop_busy@6", busy, 1);
         end
         if (c == 7) begin
            check("stop_done@7", done, 0);
            check("stop_busy@7", busy, 0);
         end
         stop = (c == 4 || c == 7);   // stop in IDLE is ignored
         step();
      end
      stop = 1'b0;
      check("stop_idle", busy, 0);

      // ---- div 0 behaves as 1 (period 4), start while busy ignored, reset
      launch(0, 0, 4'b1111);
      for (int c = 0; c < 8; c++) begin
         if (c == 1) check("d0_oc@1", out_clk, 0);
         if (c == 2) begin
            check("d0_oc@2", out_clk, 1);
            check("d0_tick@2", sample_tick, 1);
         end
         if (c == 4) check("d0_oc@4", out_clk, 0);
         if (c == 6) begin
            check("d0_oc@6", out_clk, 1);
            check("d0_tick@6", sample_tick, 1);
         end
         if (c == 3) begin
            div_val = 5; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         if (c == 7) begin
            check("d0_busy@7", busy, 1);
            rst = 1'b1;
         end
         step();
      end
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_oc", out_clk, 0);
      check("rst_mid_en", enable, 0);
      rst = 1'b0;
      step();
      check("rst_after_done", done, 0);
      check("rst_after_busy", busy, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
